// File: rtl/mem_pkg.sv
// Shared types and defaults for the two-phase 32-bit over 16-bit SRAM memory stage.
package mem_pkg;
  typedef enum logic [1:0] {IDLE, LOW, HIGH, DONE} state_t;

  localparam int SRAM_DW          = 16;
  localparam int WAIT_CYCLES_DEF  = 5;
  localparam int ADDR_OFFSET_DEF  = 1024;
endpackage

// File: rtl/sram_mem_controller.sv
// MEM-stage controller: runs one 32-bit load/store as two half-word phases on an
// async 16-bit SRAM and holds the pipeline frozen (ready=0) until it completes.
module sram_mem_controller
  import mem_pkg::*;
#(
  parameter int WAIT_CYCLES = WAIT_CYCLES_DEF,
  parameter int ADDR_OFFSET = ADDR_OFFSET_DEF,
  parameter int SRAM_AW     = 18
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               wr_en,
  input  logic               rd_en,
  input  logic [31:0]        address,
  input  logic [31:0]        write_data,
  output logic [31:0]        read_data,
  output logic               ready,
  output logic [SRAM_AW-1:0] sram_addr,
  output logic [SRAM_DW-1:0] sram_dq_out,
  input  logic [SRAM_DW-1:0] sram_dq_in,
  output logic               sram_dq_oe,
  output logic               sram_we_n,
  output logic               sram_oe_n,
  output logic               sram_ce_n
);
  localparam int            CW   = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(WAIT_CYCLES - 1);

  state_t             state;
  logic [CW-1:0]      cnt;
  logic               op_wr;
  logic               req, last, busy, half, wr_phase, rd_phase;
  logic [SRAM_AW-2:0] word;

  assign req  = rd_en | wr_en;
  assign last = (cnt == LAST);
  assign busy = (state == LOW) || (state == HIGH);
  assign half = (state == HIGH);
  // Only the low SRAM_AW-1 bits of the word index reach the pads.
  assign word = (SRAM_AW-1)'((address - 32'(ADDR_OFFSET)) >> 2);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      cnt       <= '0;
      op_wr     <= 1'b0;
      read_data <= '0;
    end else begin
      case (state)
        IDLE: if (req) begin
          state <= LOW;
          cnt   <= '0;
          op_wr <= wr_en;   // write wins when both are asserted
        end
        LOW: if (last) begin
          cnt   <= '0;
          state <= HIGH;
          if (!op_wr) read_data[15:0] <= sram_dq_in;
        end else cnt <= cnt + 1'b1;
        HIGH: if (last) begin
          cnt   <= '0;
          state <= DONE;
          if (!op_wr) read_data[31:16] <= sram_dq_in;
        end else cnt <= cnt + 1'b1;
        default: state <= IDLE;
      endcase
    end
  end

  assign wr_phase = busy & op_wr;
  assign rd_phase = busy & ~op_wr;

  assign ready       = (state == IDLE) ? ~req : (state == DONE);
  assign sram_ce_n   = ~busy;
  assign sram_dq_oe  = wr_phase;
  assign sram_oe_n   = ~rd_phase;
  // WE rises one cycle before the phase ends so data is held past the edge.
  assign sram_we_n   = ~(wr_phase & ~last);
  assign sram_addr   = busy ? {word, half} : '0;
  assign sram_dq_out = wr_phase ? (half ? write_data[31:16] : write_data[15:0]) : '0;
endmodule
